// File: rtl/two_digit_bcd_down_cntr.sv
// ---------------------------------------------------------------------------
// two_digit_bcd_down_cntr
//
// Two-digit BCD down counter (00..99) with parallel load, a decrement enable
// and a borrow output for cascading.
//
// Input priority at each rising clk edge: load, then cnt_en, then hold.
// On a load, any digit above 9 is clamped to 9. load_err then pulses for
// exactly one cycle.
//
// Optional build macro:
//   BCD_DOWN_CNTR_SAT_EN - when defined, decrementing at 00 holds the count
//                          at 00 (saturate). When undefined, 00 wraps to 99.
//                          In both builds borrow still pulses at 00.
//
// Ports:
//   clk       in   1  sole clock, rising edge
//   rstn      in   1  asynchronous active-low reset
//   load      in   1  parallel load request
//   load_val  in   8  load value {tens, ones}
//   cnt_en    in   1  decrement enable
//   count     out  8  current value {tens, ones}, registered
//   zero      out  1  count == 00, decoded from the count register
//   borrow    out  1  cnt_en & ~load & (count == 00), combinational
//   load_err  out  1  registered one-cycle pulse after a non-BCD load
// ---------------------------------------------------------------------------
module two_digit_bcd_down_cntr (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       cnt_en,
    output logic [7:0] count,
    output logic       zero,
    output logic       borrow,
    output logic       load_err
);

    logic [7:0] r_count;
    logic       r_load_err;
    logic [7:0] w_next_count;
    logic       w_next_load_err;
    logic       w_at_zero;

    // Clamp a digit into the BCD range; anything above 9 becomes 9.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        logic [3:0] res;
        if (d > 4'd9) begin
            res = 4'd9;
        end else begin
            res = d;
        end
        return res;
    endfunction

    // Flag a digit that is not a legal BCD code.
    function automatic logic bad_bcd(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    assign w_at_zero = (r_count == 8'h00);

    // Next-state decode: load beats decrement, decrement beats hold.
    always_comb begin
        w_next_count    = r_count;
        w_next_load_err = 1'b0;
        if (load) begin
            w_next_count    = {clamp_bcd(load_val[7:4]), clamp_bcd(load_val[3:0])};
            w_next_load_err = bad_bcd(load_val[7:4]) | bad_bcd(load_val[3:0]);
        end else if (cnt_en) begin
            if (r_count[3:0] == 4'd0) begin
                // The ones digit underflows, so it borrows from the tens digit.
                if (r_count[7:4] == 4'd0) begin
`ifdef BCD_DOWN_CNTR_SAT_EN
                    w_next_count = 8'h00;
`else
                    w_next_count = 8'h99;
`endif
                end else begin
                    w_next_count = {r_count[7:4] - 4'd1, 4'd9};
                end
            end else begin
                w_next_count = {r_count[7:4], r_count[3:0] - 4'd1};
            end
        end else begin
            w_next_count = r_count;
        end
    end

    // State registers; reset drives the count to 00 and clears the error pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count    <= 8'h00;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_next_count;
            r_load_err <= w_next_load_err;
        end
    end

    assign count    = r_count;
    assign load_err = r_load_err;
    assign zero     = w_at_zero;
    // The cascade borrow is only meaningful when this stage actually steps.
    assign borrow   = cnt_en & ~load & w_at_zero;

endmodule

// File: tb/tb_two_digit_bcd_down_cntr.sv
// ---------------------------------------------------------------------------
// tb_two_digit_bcd_down_cntr
//
// Self-checking bench for two_digit_bcd_down_cntr. A decimal integer model
// predicts the next count, load_err and zero for every driven cycle and
// pushes the prediction to a scoreboard queue. The queue is popped after the
// edge and compared with the DUT outputs. Define BCD_DOWN_CNTR_SAT_EN to
// check the saturating build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_two_digit_bcd_down_cntr;

    logic       clk;
    logic       rstn;
    logic       load;
    logic [7:0] load_val;
    logic       cnt_en;
    logic [7:0] count;
    logic       zero;
    logic       borrow;
    logic       load_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] cnt;
        logic       err;
        logic       zro;
    } exp_t;

    exp_t sb[$];
    int   m_val;

    two_digit_bcd_down_cntr dut (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load),
        .load_val (load_val),
        .cnt_en   (cnt_en),
        .count    (count),
        .zero     (zero),
        .borrow   (borrow),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    // Drive one cycle and predict its result. The borrow value is sampled
    // before the edge. The prediction is queued, then popped after the edge.
    task automatic run_cycle(input logic l, input logic [7:0] v, input logic e,
                             output exp_t ex, output logic exp_b, output logic obs_b);
        exp_t nx;
        int   t;
        int   o;
        load     = l;
        load_val = v;
        cnt_en   = e;
        exp_b    = e && !l && (m_val == 0);
        nx.err   = 1'b0;
        if (l) begin
            t      = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
            o      = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
            nx.err = (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
            m_val  = t * 10 + o;
        end else if (e) begin
`ifdef BCD_DOWN_CNTR_SAT_EN
            m_val = (m_val == 0) ? 0 : m_val - 1;
`else
            m_val = (m_val + 99) % 100;
`endif
        end
        nx.cnt = to_bcd(m_val);
        nx.zro = (m_val == 0);
        sb.push_back(nx);
        #1;
        obs_b = borrow;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            ex.cnt = 8'hxx;
            ex.err = 1'bx;
            ex.zro = 1'bx;
        end else begin
            ex = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        exp_t ex;
        logic eb;
        logic ob;
        rstn     = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;
        cnt_en   = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (count !== 8'h00 || zero !== 1'b1 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: count=%h zero=%b err=%b expected 00/1/0", count, zero, load_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (count !== 8'h00 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_held: count=%h zero=%b expected 00/1", count, zero);
        end
        rstn  = 1'b1;
        m_val = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b0, 8'h00, 1'b0, ex, eb, ob);
            checks++;
            if (count !== ex.cnt || zero !== ex.zro || load_err !== ex.err) begin
                errors++;
                $display("FAIL reset_hold[%0d]: count=%h zero=%b err=%b expected %h/%b/%b",
                         i, count, zero, load_err, ex.cnt, ex.zro, ex.err);
            end
        end
    endtask

    task automatic test_load_countdown();
        exp_t ex;
        logic eb;
        logic ob;
        logic [7:0] seq [5] = '{8'h23, 8'h22, 8'h21, 8'h20, 8'h19};
        for (int i = 0; i < 5; i++) begin
            run_cycle((i == 0), 8'h23, (i != 0), ex, eb, ob);
            checks++;
            if (count !== ex.cnt || count !== seq[i] || zero !== 1'b0 || load_err !== ex.err) begin
                errors++;
                $display("FAIL countdown[%0d]: count=%h zero=%b err=%b expected %h/0/%b",
                         i, count, zero, load_err, seq[i], ex.err);
            end
        end
    endtask

    task automatic test_terminal();
        exp_t ex;
        logic eb;
        logic ob;
        for (int i = 0; i < 3; i++) begin
            run_cycle((i == 0), 8'h01, (i != 0), ex, eb, ob);
            checks++;
            if (count !== ex.cnt || zero !== ex.zro || ob !== eb) begin
                errors++;
                $display("FAIL terminal[%0d]: count=%h zero=%b borrow=%b expected %h/%b/%b",
                         i, count, zero, ob, ex.cnt, ex.zro, eb);
            end
        end
`ifdef BCD_DOWN_CNTR_SAT_EN
        checks++;
        if (count !== 8'h00) begin
            errors++;
            $display("FAIL terminal_sat: count=%h expected 00", count);
        end
`else
        checks++;
        if (count !== 8'h99) begin
            errors++;
            $display("FAIL terminal_wrap: count=%h expected 99", count);
        end
`endif
    endtask

    task automatic test_invalid_load();
        exp_t ex;
        logic eb;
        logic ob;
        logic [7:0] vals [4] = '{8'hA7, 8'h00, 8'hFC, 8'h00};
        logic       lds  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_cycle(lds[i], vals[i], 1'b0, ex, eb, ob);
            checks++;
            if (count !== ex.cnt || load_err !== ex.err || zero !== ex.zro) begin
                errors++;
                $display("FAIL invalid_load[%0d]: count=%h err=%b expected %h/%b",
                         i, count, load_err, ex.cnt, ex.err);
            end
        end
    endtask

    task automatic test_collision();
        exp_t ex;
        logic eb;
        logic ob;
        run_cycle(1'b1, 8'h00, 1'b0, ex, eb, ob);
        checks++;
        if (count !== 8'h00 || zero !== 1'b1) begin
            errors++;
            $display("FAIL collision_setup: count=%h zero=%b expected 00/1", count, zero);
        end
        run_cycle(1'b1, 8'h50, 1'b1, ex, eb, ob);
        checks++;
        if (ob !== 1'b0 || count !== ex.cnt || count !== 8'h50) begin
            errors++;
            $display("FAIL collision: borrow=%b count=%h expected 0/50", ob, count);
        end
    endtask

    task automatic test_async_reset();
        exp_t ex;
        logic eb;
        logic ob;
        run_cycle(1'b1, 8'h47, 1'b0, ex, eb, ob);
        checks++;
        if (count !== 8'h47) begin
            errors++;
            $display("FAIL async_setup: count=%h expected 47", count);
        end
        load   = 1'b0;
        cnt_en = 1'b1;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (count !== 8'h00 || zero !== 1'b1 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL async_mid: count=%h zero=%b err=%b expected 00/1/0", count, zero, load_err);
        end
        #1 rstn = 1'b1;
        m_val = 0;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 8'h00, 1'b1, ex, eb, ob);
            checks++;
            if (count !== ex.cnt || zero !== ex.zro || ob !== eb) begin
                errors++;
                $display("FAIL async_resume[%0d]: count=%h borrow=%b expected %h/%b",
                         i, count, ob, ex.cnt, eb);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t ex;
        logic eb;
        logic ob;
        logic l;
        logic e;
        logic [7:0] v;
        for (int i = 0; i < 60; i++) begin
            l = ($urandom_range(0, 5) == 0);
            e = ($urandom_range(0, 3) != 0);
            v = 8'($urandom_range(0, 255));
            run_cycle(l, v, e, ex, eb, ob);
            checks++;
            if (count !== ex.cnt || zero !== ex.zro || load_err !== ex.err || ob !== eb) begin
                errors++;
                $display("FAIL random[%0d]: count=%h zero=%b err=%b borrow=%b expected %h/%b/%b/%b",
                         i, count, zero, load_err, ob, ex.cnt, ex.zro, ex.err, eb);
            end
        end
    endtask

    initial begin
        m_val = 0;
        test_reset();
        test_load_countdown();
        test_terminal();
        test_invalid_load();
        test_collision();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/two_digit_bcd_down_cntr.md
TWO_DIGIT_BCD_DOWN_CNTR -- requirements
Module: two_digit_bcd_down_cntr

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rstn.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  parallel load request; sampled at the clk rising edge.
REQ-006 load_val  input  8  load value; [7:4] is the tens BCD digit, [3:0] is the ones BCD digit.
REQ-007 cnt_en  input  1  decrement enable; sampled at the clk rising edge.
REQ-008 count  output  8  current value; [7:4] is tens, [3:0] is ones; registered.
REQ-009 zero  output  1  high while count == 8'h00; decoded from the count register only.
REQ-010 borrow  output  1  combinational cascade output; equals cnt_en & ~load & (count == 8'h00).
REQ-011 load_err  output  1  registered one-cycle pulse flagging a non-BCD load digit.

Function
REQ-012 Input priority at each rising edge SHALL be: load, then cnt_en, then hold.
REQ-013 load=1: count SHALL take load_val at the next edge, one-cycle latency.
REQ-014 load=1 with either digit > 9: each invalid digit SHALL be clamped to 9, any valid digit SHALL load unchanged, and load_err SHALL be 1 for the following cycle only.
REQ-015 load=0, cnt_en=1: the ones digit SHALL decrement by 1; ones 0 SHALL go to 9 and borrow one from tens.
REQ-016 A tens borrow with tens = 0 SHALL wrap tens to 9, so 8'h00 goes to 8'h99, unless the macro in REQ-024 is defined.
REQ-017 load=0, cnt_en=0: count SHALL hold.
REQ-018 load=1 with cnt_en=1: the load SHALL win, no decrement SHALL occur in that cycle, and borrow SHALL be 0.
REQ-019 load_err SHALL be 0 in every cycle that does not follow an invalid load.
REQ-020 count SHALL never hold a non-BCD digit after reset; every reachable value SHALL be 00..99.
REQ-021 Single-cycle decrement: one count step per enabled edge, no multicycle paths.

Reset
REQ-022 rstn low SHALL immediately force count=8'h00 and load_err=0, independent of clk; zero SHALL then be 1.
REQ-023 Reset asserted mid-count or during a load cycle SHALL override that cycle. The first edge after rstn deasserts SHALL act on the load and cnt_en values present at that edge.

Configuration
REQ-024 Macro BCD_DOWN_CNTR_SAT_EN SHALL control terminal behaviour at 8'h00.
  - Defined: at 8'h00 with cnt_en=1 and load=0, count SHALL hold at 8'h00 (saturate) and borrow SHALL still pulse as in REQ-010.
  - Not defined: count SHALL wrap 8'h00 to 8'h99 as in REQ-016.
REQ-025 Load behaviour, load_err and zero SHALL be identical with or without the macro.

Verification
REQ-026 Reset then hold: rstn=0 then 1, load=0, cnt_en=0 for 5 clks -> count=8'h00, zero=1, load_err=0 throughout.
REQ-027 Load and count down: load 8'h23, then cnt_en=1 for 4 clks -> count sequence 23, 22, 21, 20, 19; zero=0 throughout.
REQ-028 Terminal count: load 8'h01, then cnt_en=1 for 2 clks -> count 01, 00, then 99 (macro undefined) or 00 (macro defined); borrow=1 exactly while count=00 with cnt_en=1.
REQ-029 Invalid load: load_val=8'hA7 -> count=8'h97 and load_err=1 for one cycle; then load_val=8'hFC -> count=8'h99 and load_err=1 for one cycle.
REQ-030 Load/enable collision: at count=8'h00, load=1 with load_val=8'h50 and cnt_en=1 -> borrow=0 in that cycle and count=8'h50 next cycle.
REQ-031 Asynchronous reset mid-run: count at 8'h47 with cnt_en=1, rstn pulsed low between edges -> count=8'h00 before the next clk edge, and decrementing from 8'h00 resumes after release.
